divider: RTL and testbench



---
 rtl/divider.sv | 157 +++++++++++++++
 tb/tb_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle signed restoring divider, one quotient bit per clock.
// Start/done handshake; busy stays high from accept until the done pulse.
// Optional build macro DIVIDER_EARLY_EXIT_EN: when |a| < |b| the iterations
// are skipped and the result (quotient 0, remainder a) is produced in two cycles.
module divider #(
    parameter int n = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [n-1:0] a,
    input  logic signed [n-1:0] b,
    output logic signed [n-1:0] quotient,
    output logic signed [n-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state;
    logic signed [n-1:0] a_reg;     // original dividend, returned as remainder on b == 0
    logic        [n-1:0] dvd;       // |a|, shifted out MSB first
    logic        [n-1:0] mag_b;     // |b|
    logic        [n-1:0] qbits;     // unsigned quotient magnitude
    logic        [n-1:0] prem;      // partial remainder, always < |b| <= 2^(n-1)
    logic        [CW-1:0] count;
    logic                sign_q;
    logic                sign_r;
    logic                zero_b;

    logic        [n:0]   shifted;
    logic        [n:0]   trial;
    logic        [n-1:0] mag_a_in;
    logic        [n-1:0] mag_b_in;
    logic                b_zero_in;
    logic                early_in;

    // Unsigned magnitude; the most negative value maps to 2^(n-1), which fits.
    function automatic logic [n-1:0] magnitude(input logic signed [n-1:0] v);
        logic [n-1:0] u;
        u = v;
        return v[n-1] ? (~u + 1'b1) : u;
    endfunction

    // Re-apply a sign to a magnitude, modulo 2^n (gives natural wrap on overflow).
    function automatic logic [n-1:0] apply_sign(input logic [n-1:0] m, input logic neg);
        return neg ? (~m + 1'b1) : m;
    endfunction

    // Operand magnitudes and shortcut decisions evaluated on the accept edge.
    always_comb begin
        mag_a_in  = magnitude(a);
        mag_b_in  = magnitude(b);
        b_zero_in = (b == '0);
`ifdef DIVIDER_EARLY_EXIT_EN
        early_in  = !b_zero_in && (mag_a_in < mag_b_in);
`else
        early_in  = 1'b0;
`endif
    end

    // One restoring step: shift in the next dividend bit, trial-subtract |b|.
    always_comb begin
        shifted = {prem, dvd[n-1]};
        trial   = shifted - {1'b0, mag_b};
    end

    // Control FSM with registered results; count also times the short paths.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            dvd         <= '0;
            mag_b       <= '0;
            qbits       <= '0;
            prem        <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_b      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg       <= a;
                        dvd         <= mag_a_in;
                        mag_b       <= mag_b_in;
                        qbits       <= '0;
                        sign_q      <= a[n-1] ^ b[n-1];
                        sign_r      <= a[n-1];
                        zero_b      <= b_zero_in;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        if (b_zero_in || early_in) begin
                            // Short path: the remainder is the whole dividend,
                            // and one wait cycle in FINISH aligns done to T+2.
                            prem  <= mag_a_in;
                            count <= CW'(1);
                            state <= FINISH;
                        end else begin
                            prem  <= '0;
                            count <= CW'(n);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[n-2:0], 1'b0};
                    if (!trial[n]) begin
                        prem  <= trial[n-1:0];
                        qbits <= {qbits[n-2:0], 1'b1};
                    end else begin
                        prem  <= shifted[n-1:0];
                        qbits <= {qbits[n-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        if (zero_b) begin
                            quotient    <= '1;
                            remainder   <= a_reg;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= signed'(apply_sign(qbits, sign_q));
                            remainder   <= signed'(apply_sign(prem, sign_r));
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (n = 8): vector table plus handshake corner cases.
module tb_divider;

    localparam int N = 8;
`ifdef DIVIDER_EARLY_EXIT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = N + 1;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic signed [N-1:0] a = '0;
    logic signed [N-1:0] b = '0;
    logic signed [N-1:0] quotient;
    logic signed [N-1:0] remainder;
    logic                busy;
    logic                done;
    logic                div_by_zero;

    int nvec  = 0;
    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        logic       early;
    } vec_t;

    vec_t vecs[19];

    divider #(.n(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Present operands with start for one edge (T); returns 1ns after T.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges after T until done is seen; bounded.
    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int exp_lat;
        exp_lat = v.z ? 2 : (v.early ? EARLY_LAT : N + 1);
        start_op(v.a, v.b);
        check("busy_after_accept", 8'(busy), 8'd1);
        check("dz_cleared_on_accept", 8'(div_by_zero), 8'd0);
        wait_done(0, lat);
        check("latency", 8'(lat), 8'(exp_lat));
        check("quotient", quotient, v.q);
        check("remainder", remainder, v.r);
        check("div_by_zero", 8'(div_by_zero), 8'(v.z));
        check("busy_at_done", 8'(busy), 8'd0);
        @(posedge clock);
        #1;
        check("done_one_cycle", 8'(done), 8'd0);
        check("quotient_hold", quotient, v.q);
        check("dz_hold", 8'(div_by_zero), 8'(v.z));
        nvec++;
    endtask

    initial begin
        int lat;

        vecs[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        vecs[5]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[6]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h03, 8'h32, 8'h00, 8'h03, 1'b0, 1'b1};
        vecs[9]  = '{8'hFD, 8'h32, 8'h00, 8'hFD, 1'b0, 1'b1};
        vecs[10] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b1};
        vecs[11] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0};
        vecs[14] = '{8'h07, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b1};
        vecs[16] = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};
        vecs[18] = '{8'h7F, 8'hFF, 8'h81, 8'h00, 1'b0, 1'b0};

        // Asynchronous reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_quotient", quotient, 8'h00);
        check("rst_remainder", remainder, 8'h00);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_dz", 8'(div_by_zero), 8'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start while busy is ignored; operands changing after accept have no effect.
        start_op(8'h64, 8'h07);
        repeat (2) @(posedge clock);
        #1;
        a = 8'h32;
        b = 8'h05;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(3, lat);
        check("ignore_latency", 8'(lat), 8'd9);
        check("ignore_quotient", quotient, 8'h0E);
        check("ignore_remainder", remainder, 8'h02);
        nvec++;

        // start held during the done cycle is accepted on the following edge.
        a = 8'h32;
        b = 8'h05;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_done_low", 8'(done), 8'd0);
        check("b2b_busy", 8'(busy), 8'd1);
        wait_done(0, lat);
        check("b2b_latency", 8'(lat), 8'd9);
        check("b2b_quotient", quotient, 8'h0A);
        check("b2b_remainder", remainder, 8'h00);
        nvec++;

        // Reset mid-operation discards the result immediately.
        start_op(8'h64, 8'h07);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("midrst_quotient", quotient, 8'h00);
        check("midrst_remainder", remainder, 8'h00);
        check("midrst_busy", 8'(busy), 8'd0);
        check("midrst_done", 8'(done), 8'd0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_stays_idle", 8'(busy), 8'd0);
        start_op(8'h32, 8'h05);
        wait_done(0, lat);
        check("postrst_latency", 8'(lat), 8'd9);
        check("postrst_quotient", quotient, 8'h0A);
        check("postrst_remainder", remainder, 8'h00);
        check("postrst_dz", 8'(div_by_zero), 8'd0);
        nvec++;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
